// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - TinyPong geometry constants, derived positions and game state enum
package pong_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int BALL_SIZE    = 8;
  localparam int PADDLE_X     = 16;
  localparam int PADDLE_W     = 8;
  localparam int PADDLE_H     = 64;
  localparam int BALL_SPEED   = 2;
  localparam int PADDLE_SPEED = 4;
  localparam int SERVE_FRAMES = 60;
  localparam int START_LIVES  = 3;

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [9:0] CENTER_X    = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] CENTER_Y    = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] PADDLE_CTR  = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [9:0] PADDLE_MAX  = 10'(V_ACTIVE - PADDLE_H);
  localparam logic [9:0] BALL_X_MAX  = 10'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0] BALL_Y_MAX  = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0] PADDLE_EDGE = 10'(PADDLE_X + PADDLE_W);

  // Direction bit: 0 moves towards larger coordinates, so reset and first serve are both "+".
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_e;

  function automatic logic [10:0] wide(input logic [9:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/pong_ball_step.sv
// rtl/pong_ball_step.sv - one-frame ball motion: wall bounces, paddle hit and miss detection
module pong_ball_step
  import pong_pkg::*;
(
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_y,
  input  logic       dx,
  input  logic       dy,
  output logic [9:0] ball_x_nxt,
  output logic [9:0] ball_y_nxt,
  output logic       dx_nxt,
  output logic       dy_nxt,
  output logic       hit,
  output logic       miss
);

  logic [10:0] bx;
  logic [10:0] by;
  logic [10:0] py;
  logic        overlap;

  assign bx = wide(ball_x);
  assign by = wide(ball_y);
  assign py = wide(paddle_y);
  assign overlap = (by + 11'(BALL_SIZE) > py) && (by < py + 11'(PADDLE_H));

  always_comb begin
    ball_y_nxt = ball_y;
    dy_nxt     = dy;
    if (dy == DIR_NEG) begin
      if (by < 11'(BALL_SPEED)) begin
        ball_y_nxt = '0;
        dy_nxt     = DIR_POS;
      end else begin
        ball_y_nxt = ball_y - 10'(BALL_SPEED);
      end
    end else begin
      if (by + 11'(BALL_SIZE + BALL_SPEED) > 11'(V_ACTIVE)) begin
        ball_y_nxt = BALL_Y_MAX;
        dy_nxt     = DIR_NEG;
      end else begin
        ball_y_nxt = ball_y + 10'(BALL_SPEED);
      end
    end
  end

  // A hit requires the ball to cross the paddle face during this step.
  always_comb begin
    ball_x_nxt = ball_x;
    dx_nxt     = dx;
    hit        = 1'b0;
    miss       = 1'b0;
    if (dx == DIR_POS) begin
      if (bx + 11'(BALL_SIZE + BALL_SPEED) > 11'(H_ACTIVE)) begin
        ball_x_nxt = BALL_X_MAX;
        dx_nxt     = DIR_NEG;
      end else begin
        ball_x_nxt = ball_x + 10'(BALL_SPEED);
      end
    end else if (bx >= wide(PADDLE_EDGE) && bx - 11'(BALL_SPEED) < wide(PADDLE_EDGE)
                 && overlap) begin
      ball_x_nxt = PADDLE_EDGE;
      dx_nxt     = DIR_POS;
      hit        = 1'b1;
    end else if (bx < 11'(BALL_SPEED)) begin
      miss = 1'b1;
    end else begin
      ball_x_nxt = ball_x - 10'(BALL_SPEED);
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - TinyPong frame-rate sequencer: serve/play/over FSM, paddle, score and lives
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_y,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       hit_pulse,
  output logic       miss_pulse
);

  state_e           state_q, state_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [9:0]       ball_y_q, ball_y_d;
  logic [9:0]       paddle_y_q, paddle_y_d;
  logic             dx_q, dx_d;
  logic             dy_q, dy_d;
  logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
  logic             serve_dir_q, serve_dir_d;
  logic [7:0]       score_q, score_d;
  logic [1:0]       lives_q, lives_d;
  logic             btn_prev_q, btn_prev_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;

  logic [9:0] step_x, step_y, paddle_mv;
  logic       step_dx, step_dy, step_hit, step_miss;
  logic       tick, btn_any;

  assign tick    = ena & frame_tick;
  assign btn_any = btn_up | btn_down;

  pong_ball_step u_step (
    .ball_x     (ball_x_q),
    .ball_y     (ball_y_q),
    .paddle_y   (paddle_y_q),
    .dx         (dx_q),
    .dy         (dy_q),
    .ball_x_nxt (step_x),
    .ball_y_nxt (step_y),
    .dx_nxt     (step_dx),
    .dy_nxt     (step_dy),
    .hit        (step_hit),
    .miss       (step_miss)
  );

  always_comb begin
    paddle_mv = paddle_y_q;
    if (btn_up && !btn_down) begin
      paddle_mv = (paddle_y_q < 10'(PADDLE_SPEED)) ? '0 : paddle_y_q - 10'(PADDLE_SPEED);
    end else if (btn_down && !btn_up) begin
      paddle_mv = (paddle_y_q > PADDLE_MAX - 10'(PADDLE_SPEED)) ? PADDLE_MAX
                                                                : paddle_y_q + 10'(PADDLE_SPEED);
    end
  end

  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    paddle_y_d  = paddle_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    serve_cnt_d = serve_cnt_q;
    serve_dir_d = serve_dir_q;
    score_d     = score_q;
    lives_d     = lives_q;
    btn_prev_d  = btn_prev_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;

    if (tick) begin
      btn_prev_d = btn_any;
      case (state_q)
        SERVE: begin
          paddle_y_d = paddle_mv;
          ball_x_d   = CENTER_X;
          ball_y_d   = CENTER_Y;
          if (serve_cnt_q != '0) begin
            serve_cnt_d = serve_cnt_q - 1'b1;
          end else begin
            state_d     = PLAY;
            dx_d        = DIR_POS;
            dy_d        = serve_dir_q;
            serve_dir_d = ~serve_dir_q;
          end
        end
        PLAY: begin
          paddle_y_d = paddle_mv;
          ball_x_d   = step_x;
          ball_y_d   = step_y;
          dx_d       = step_dx;
          dy_d       = step_dy;
          hit_d      = step_hit;
          if (step_hit && score_q != 8'hFF) begin
            score_d = score_q + 8'd1;
          end
          if (step_miss) begin
            miss_d  = 1'b1;
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              // Last life: the ball stays where the miss happened for the game-over screen.
              state_d  = OVER;
              ball_x_d = ball_x_q;
              ball_y_d = ball_y_q;
              dx_d     = dx_q;
              dy_d     = dy_q;
            end else begin
              state_d     = SERVE;
              ball_x_d    = CENTER_X;
              ball_y_d    = CENTER_Y;
              serve_cnt_d = CNT_W'(SERVE_FRAMES);
            end
          end
        end
        OVER: begin
          if (btn_any && !btn_prev_q) begin
            state_d     = SERVE;
            score_d     = '0;
            lives_d     = 2'(START_LIVES);
            ball_x_d    = CENTER_X;
            ball_y_d    = CENTER_Y;
            paddle_y_d  = PADDLE_CTR;
            serve_cnt_d = CNT_W'(SERVE_FRAMES);
          end
        end
        default: state_d = SERVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SERVE;
      ball_x_q    <= CENTER_X;
      ball_y_q    <= CENTER_Y;
      paddle_y_q  <= PADDLE_CTR;
      dx_q        <= DIR_POS;
      dy_q        <= DIR_POS;
      serve_cnt_q <= CNT_W'(SERVE_FRAMES);
      serve_dir_q <= 1'b0;
      score_q     <= '0;
      lives_q     <= 2'(START_LIVES);
      btn_prev_q  <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      paddle_y_q  <= paddle_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      serve_cnt_q <= serve_cnt_d;
      serve_dir_q <= serve_dir_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      btn_prev_q  <= btn_prev_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign paddle_y   = paddle_y_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign game_over  = (state_q == OVER);
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - scoreboard bench for pong_game_ctrl against a frame-level game model
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       frame_tick;
  logic       btn_up;
  logic       btn_down;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] paddle_y;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;
  logic       hit_pulse;
  logic       miss_pulse;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .frame_tick (frame_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle_y   (paddle_y),
    .score      (score),
    .lives      (lives),
    .game_over  (game_over),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse)
  );

  typedef struct {
    int bx, by, py, score, lives, over, hit, miss;
    int dfield, dval;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  logic tick_seen;
  bit   done = 0;
  bit   done_chk = 0;
  bit   bound_hit = 0;

  // Game model: signed velocities, mode 0 = serving, 1 = rally, 2 = game over.
  int m_bx, m_by, m_py, m_vx, m_vy, m_cnt, m_score, m_lives, m_mode, m_sdir, m_prev, m_hit, m_miss;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_bx = 316; m_by = 236; m_py = 208; m_vx = 2; m_vy = 2; m_cnt = 60;
    m_score = 0; m_lives = 3; m_mode = 0; m_sdir = 0; m_prev = 0; m_hit = 0; m_miss = 0;
  endtask

  task automatic model_tick(input bit up, input bit dn);
    int npy, nbx, nby, nvx, nvy;
    int any;
    any = (up || dn) ? 1 : 0;
    m_hit = 0;
    m_miss = 0;
    npy = m_py;
    if (m_mode != 2) begin
      if (up && !dn) npy = (m_py - 4 < 0) ? 0 : m_py - 4;
      else if (dn && !up) npy = (m_py + 4 > 416) ? 416 : m_py + 4;
    end
    if (m_mode == 0) begin
      if (m_cnt > 0) m_cnt--;
      else begin
        m_mode = 1; m_vx = 2; m_vy = (m_sdir != 0) ? -2 : 2; m_sdir = 1 - m_sdir;
      end
    end else if (m_mode == 1) begin
      nvy = m_vy;
      if (m_vy < 0 && m_by < 2) begin nby = 0; nvy = 2; end
      else if (m_vy > 0 && m_by + 10 > 480) begin nby = 472; nvy = -2; end
      else nby = m_by + m_vy;
      nvx = m_vx;
      nbx = m_bx;
      if (m_vx > 0 && m_bx + 10 > 640) begin nbx = 632; nvx = -2; end
      else if (m_vx < 0 && m_bx >= 24 && m_bx - 2 < 24 && m_by + 8 > m_py && m_by < m_py + 64) begin
        nbx = 24; nvx = 2; m_hit = 1;
        if (m_score < 255) m_score++;
      end else if (m_vx < 0 && m_bx < 2) m_miss = 1;
      else nbx = m_bx + m_vx;
      if (m_miss != 0) begin
        m_lives--;
        if (m_lives == 0) m_mode = 2;
        else begin m_mode = 0; m_bx = 316; m_by = 236; m_cnt = 60; end
      end else begin
        m_bx = nbx; m_by = nby; m_vx = nvx; m_vy = nvy;
      end
    end else if (any != 0 && m_prev == 0) begin
      m_score = 0; m_lives = 3; m_bx = 316; m_by = 236; npy = 208; m_cnt = 60; m_mode = 0;
    end
    m_py = npy;
    m_prev = any;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Called one time unit after a rising edge; the tick is taken at the next edge.
  task automatic tick(input bit up, input bit dn, input bit en, input int dfield = 0, input int dval = 0);
    exp_t e;
    btn_up = up; btn_down = dn; ena = en; frame_tick = 1'b1;
    if (en) model_tick(up, dn);
    else begin m_hit = 0; m_miss = 0; end
    e.bx = m_bx; e.by = m_by; e.py = m_py; e.score = m_score; e.lives = m_lives;
    e.over = (m_mode == 2) ? 1 : 0; e.hit = m_hit; e.miss = m_miss;
    e.dfield = dfield; e.dval = dval;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    ena = 1'b1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) idle();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_seen <= 1'b0;
    else tick_seen <= frame_tick;
  end

  // Monitor: reset values on reset assertion, scoreboard compare after every frame_tick.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      if (!rst_n) begin
        chk("rst_ball_x", int'(ball_x), 316);
        chk("rst_ball_y", int'(ball_y), 236);
        chk("rst_paddle_y", int'(paddle_y), 208);
        chk("rst_score", int'(score), 0);
        chk("rst_lives", int'(lives), 3);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_hit_pulse", int'(hit_pulse), 0);
        chk("rst_miss_pulse", int'(miss_pulse), 0);
      end
    end else if (tick_seen) begin
      if (exp_q.size() == 0) chk("queue_underflow", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("ball_x", int'(ball_x), mon_e.bx);
        chk("ball_y", int'(ball_y), mon_e.by);
        chk("paddle_y", int'(paddle_y), mon_e.py);
        chk("score", int'(score), mon_e.score);
        chk("lives", int'(lives), mon_e.lives);
        chk("game_over", int'(game_over), mon_e.over);
        chk("hit_pulse", int'(hit_pulse), mon_e.hit);
        chk("miss_pulse", int'(miss_pulse), mon_e.miss);
        case (mon_e.dfield)
          1: chk("plan_ball_x", int'(ball_x), mon_e.dval);
          2: chk("plan_ball_y", int'(ball_y), mon_e.dval);
          3: chk("plan_paddle_y", int'(paddle_y), mon_e.dval);
          4: chk("plan_lives", int'(lives), mon_e.dval);
          default: ;
        endcase
      end
    end else begin
      chk("idle_hit_pulse", int'(hit_pulse), 0);
      chk("idle_miss_pulse", int'(miss_pulse), 0);
      if (done && !done_chk) begin
        chk("queue_drained", exp_q.size(), 0);
        chk("phase_bounds", int'(bound_hit), 0);
        done_chk <= 1'b1;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit up, dn, en;
    rst_n = 1'b0; ena = 1'b0; frame_tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Serve countdown with paddle exercise, launch, then free flight to both far walls.
    for (int k = 1; k <= 5; k++) tick(1, 1, 1, (k == 5) ? 3 : 0, 208);
    for (int k = 6; k <= 60; k++) begin
      if (k == 57) tick(1, 0, 1, 3, 0);
      else if (k == 59) tick(1, 0, 1, 1, 316);
      else if (k == 60) tick(1, 0, 1, 2, 236);
      else tick(1, 0, 1);
    end
    tick(0, 0, 1, 2, 236);
    tick(0, 0, 1, 1, 318);
    tick(0, 0, 1, 2, 240);
    for (int k = 64; k <= 221; k++) begin
      case (k)
        170: tick(0, 1, 1, 3, 416);
        179: tick(0, 1, 1, 2, 472);
        181: tick(0, 1, 1, 2, 470);
        219: tick(0, 1, 1, 1, 632);
        221: tick(0, 1, 1, 1, 630);
        default: tick(0, 1, 1);
      endcase
    end

    // Frame ticks while disabled must not move anything.
    for (int k = 0; k < 6; k++) begin
      tick($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, 0);
      gap();
    end

    // Paddle follows the ball: rallies with hits.
    for (int k = 0; k < 1000; k++) begin
      up = (m_py > m_by + 4 - 32 + 2);
      dn = (m_py < m_by + 4 - 32 - 2);
      tick(up, dn, 1);
      gap();
    end

    // Paddle dodges the ball until the game is lost.
    n = 0;
    while (m_mode != 2 && n < 8000) begin
      tick(m_by + 4 < 240, m_by + 4 >= 240, 1);
      gap();
      n++;
    end
    if (m_mode != 2) bound_hit = 1;
    for (int k = 0; k < 5; k++) tick($urandom_range(0, 1) != 0, 0, 1);
    tick(0, 0, 1);
    tick(1, 0, 1, 4, 3);
    tick(0, 0, 1, 1, 316);

    // Random buttons with occasional disabled frames.
    for (int k = 0; k < 500; k++) begin
      up = $urandom_range(0, 1) != 0;
      dn = $urandom_range(0, 1) != 0;
      en = $urandom_range(0, 7) != 0;
      tick(up, dn, en);
      gap();
    end

    // Reach a rally, then reset asynchronously between clock edges.
    n = 0;
    while (m_mode != 1 && n < 200) begin
      tick(m_mode == 2 && m_prev == 0, 0, 1);
      n++;
    end
    if (m_mode != 1) bound_hit = 1;
    for (int k = 0; k < 10; k++) tick(0, 1, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 70; k++) tick(0, 0, 1);

    done = 1;
    repeat (4) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
